// File: rtl/lbus_pkg.sv
// Shared local-bus definitions: command field positions, burst decode, SRAM-target FSM states.
package lbus_pkg;

  localparam int unsigned CMD_BE_LSB    = 0;
  localparam int unsigned CMD_WR_BIT    = 4;
  localparam int unsigned CMD_BURST_LSB = 5;

  // Wide enough for WAIT_STATES up to 15.
  localparam int unsigned WS_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StXfer,
    StTurn
  } srt_state_e;

  function automatic logic [3:0] burst_beats(input logic [1:0] code);
    logic [3:0] beats;
    unique case (code)
      2'b00:   beats = 4'd1;
      2'b01:   beats = 4'd2;
      2'b10:   beats = 4'd4;
      default: beats = 4'd8;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/lbus_srt_mem.sv
// Byte-writable word array: one synchronous write port, one asynchronous read port.
module lbus_srt_mem #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [31:0]                  wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lbus_sram_tgt.sv
// Local-bus SRAM target: window decode, programmable wait states, wrapping bursts.
// Optional write protection (SRT_WP/SRT_ERR) is built when LBUS_SRT_WRPROT_EN is defined.
module lbus_sram_tgt
  import lbus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1F00_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        BUSCLK,
  input  logic        RESET_D1_R,
  input  logic        LBC_FRAME,
  input  logic [31:0] LBC_ADDR,
  input  logic [6:0]  LBC_CMD,
  input  logic        LBC_IRDY,
  input  logic [31:0] LBC_DATA,
  input  logic        LBUS_ABORT,
`ifdef LBUS_SRT_WRPROT_EN
  input  logic        SRT_WP,
  output logic        SRT_ERR,
`endif
  output logic        SRT_SEL,
  output logic        SRT_TRDY,
  output logic [31:0] SRT_DATA,
  output logic        SRT_DOE
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [WS_W-1:0] WS_LAST = WS_W'(WAIT_STATES - 1);

  srt_state_e      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            wr_q, wr_d;
  logic [2:0]      last_q, last_d;
  logic [2:0]      beat_q, beat_d;
  logic [WS_W-1:0] wcnt_q, wcnt_d;

  logic            hit;
  logic            wp;
  logic            beat_ok;
  logic            mem_we;
  logic [31:0]     rdata;
  logic [AW-1:0]   blk_mask;
  logic [AW-1:0]   idx_inc;
  logic [AW-1:0]   idx_wrap;
  logic            unused_addr;

  assign hit = (LBC_ADDR & ADDR_MASK) == BASE_ADDR;

  // Advance only the low bits covered by the burst so the burst wraps in its aligned block.
  assign blk_mask = AW'(last_q);
  assign idx_inc  = idx_q + AW'(1);
  assign idx_wrap = (idx_q & ~blk_mask) | (idx_inc & blk_mask);

  assign beat_ok = (state_q == StXfer) && LBC_IRDY && !LBUS_ABORT;
  assign mem_we  = beat_ok && wr_q && !wp && !RESET_D1_R;

  assign unused_addr = ^{LBC_ADDR[31:AW+2], LBC_ADDR[1:0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    be_d     = be_q;
    wr_d     = wr_q;
    last_d   = last_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    SRT_SEL  = 1'b0;
    SRT_TRDY = 1'b0;
    SRT_DOE  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (LBC_FRAME && hit) begin
          idx_d   = LBC_ADDR[AW+1:2];
          be_d    = LBC_CMD[CMD_BE_LSB +: 4];
          wr_d    = LBC_CMD[CMD_WR_BIT];
          last_d  = 3'(burst_beats(LBC_CMD[CMD_BURST_LSB +: 2]) - 4'd1);
          beat_d  = '0;
          wcnt_d  = '0;
          state_d = (WAIT_STATES > 0) ? StWait : StXfer;
        end
      end
      StWait: begin
        SRT_SEL = 1'b1;
        if (LBUS_ABORT) begin
          wcnt_d  = '0;
          state_d = StIdle;
        end else if (wcnt_q == WS_LAST) begin
          wcnt_d  = '0;
          state_d = StXfer;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StXfer: begin
        SRT_SEL  = 1'b1;
        SRT_TRDY = 1'b1;
        SRT_DOE  = ~wr_q;
        if (LBUS_ABORT) begin
          beat_d  = '0;
          state_d = StIdle;
        end else if (LBC_IRDY) begin
          idx_d  = idx_wrap;
          beat_d = beat_q + 1'b1;
          if (beat_q == last_q) begin
            beat_d  = '0;
            state_d = StTurn;
          end
        end
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign SRT_DATA = SRT_DOE ? rdata : 32'h0;

  always_ff @(posedge BUSCLK) begin
    if (RESET_D1_R) begin
      state_q <= StIdle;
      idx_q   <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      last_q  <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef LBUS_SRT_WRPROT_EN
  logic err_q;

  assign wp      = SRT_WP;
  assign SRT_ERR = err_q;

  // One-cycle flag for each write beat that protection suppressed.
  always_ff @(posedge BUSCLK) begin
    if (RESET_D1_R) err_q <= 1'b0;
    else            err_q <= beat_ok && wr_q && SRT_WP;
  end
`else
  assign wp = 1'b0;
`endif

  lbus_srt_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk  (BUSCLK),
    .we   (mem_we),
    .be   (be_q),
    .waddr(idx_q),
    .wdata(LBC_DATA),
    .raddr(idx_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_lbus_sram_tgt.sv
// Directed bench for lbus_sram_tgt: cycle-vector table plus burst, stall, abort and reset sequences.
module tb_lbus_sram_tgt;

  logic        BUSCLK = 1'b0;
  logic        RESET_D1_R = 1'b1;
  logic        LBC_FRAME = 1'b0;
  logic [31:0] LBC_ADDR = '0;
  logic [6:0]  LBC_CMD = '0;
  logic        LBC_IRDY = 1'b0;
  logic [31:0] LBC_DATA = '0;
  logic        LBUS_ABORT = 1'b0;
  logic        SRT_SEL;
  logic        SRT_TRDY;
  logic [31:0] SRT_DATA;
  logic        SRT_DOE;
`ifdef LBUS_SRT_WRPROT_EN
  logic        SRT_WP = 1'b0;
  logic        SRT_ERR;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];
  logic [31:0] stall_log [8];

  typedef struct {
    logic        frame;
    logic [31:0] addr;
    logic [6:0]  cmd;
    logic [31:0] data;
    logic [34:0] exp;   // {sel, trdy, doe, data}
  } vec_t;

  vec_t tbl [12];

  lbus_sram_tgt dut (
    .BUSCLK    (BUSCLK),
    .RESET_D1_R(RESET_D1_R),
    .LBC_FRAME (LBC_FRAME),
    .LBC_ADDR  (LBC_ADDR),
    .LBC_CMD   (LBC_CMD),
    .LBC_IRDY  (LBC_IRDY),
    .LBC_DATA  (LBC_DATA),
    .LBUS_ABORT(LBUS_ABORT),
`ifdef LBUS_SRT_WRPROT_EN
    .SRT_WP    (SRT_WP),
    .SRT_ERR   (SRT_ERR),
`endif
    .SRT_SEL   (SRT_SEL),
    .SRT_TRDY  (SRT_TRDY),
    .SRT_DATA  (SRT_DATA),
    .SRT_DOE   (SRT_DOE)
  );

  always #5 BUSCLK = ~BUSCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge BUSCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transfer from the current cycle; returns the number of completed beats.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                      input logic [1:0] bc, input int stall_beat, input int stall_len,
                      input int abort_beat, output int done);
    int n;
    int beat;
    int stalls;
    int guard;
    n = 1 << bc;
    step();
    LBC_FRAME = 1'b1;
    LBC_ADDR  = addr;
    LBC_CMD   = {bc, wr, be};
    LBC_IRDY  = 1'b0;
    step();
    LBC_FRAME = 1'b0;
    LBC_ADDR  = '0;
    LBC_CMD   = '0;
    beat   = 0;
    stalls = 0;
    guard  = 0;
    while (beat < n && guard < 64) begin
      guard++;
      if (!SRT_TRDY) begin
        LBC_IRDY = 1'b0;
        step();
        continue;
      end
      if (beat == abort_beat) begin
        LBC_IRDY   = 1'b1;
        LBC_DATA   = wbuf[beat];
        LBUS_ABORT = 1'b1;
        step();
        LBUS_ABORT = 1'b0;
        break;
      end
      if (beat == stall_beat && stalls < stall_len) begin
        LBC_IRDY = 1'b0;
        stall_log[stalls] = SRT_DATA;
        stalls++;
        step();
        continue;
      end
      LBC_IRDY   = 1'b1;
      LBC_DATA   = wbuf[beat];
      rbuf[beat] = SRT_DATA;
      step();
      beat++;
    end
    LBC_IRDY = 1'b0;
    LBC_DATA = '0;
    done = beat;
  endtask

  initial begin
    int done;

    tbl[0]  = '{1'b1, 32'h1F00_0010, 7'h1F, 32'h0,         {3'b000, 32'h0}};
    tbl[1]  = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b100, 32'h0}};
    tbl[2]  = '{1'b0, 32'h0,         7'h00, 32'hDEAD_BEEF, {3'b110, 32'h0}};
    tbl[3]  = '{1'b1, 32'h1F00_0010, 7'h0F, 32'h0,         {3'b000, 32'h0}};
    tbl[4]  = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b000, 32'h0}};
    tbl[5]  = '{1'b1, 32'h1F00_0010, 7'h0F, 32'h0,         {3'b000, 32'h0}};
    tbl[6]  = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b100, 32'h0}};
    tbl[7]  = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b111, 32'hDEAD_BEEF}};
    tbl[8]  = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b000, 32'h0}};
    tbl[9]  = '{1'b1, 32'h2000_0010, 7'h0F, 32'h0,         {3'b000, 32'h0}};
    tbl[10] = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b000, 32'h0}};
    tbl[11] = '{1'b0, 32'h0,         7'h00, 32'h0,         {3'b000, 32'h0}};

    repeat (3) step();
    check("reset_outputs", {SRT_SEL, SRT_TRDY, SRT_DOE, SRT_DATA}, 64'h0);
    RESET_D1_R = 1'b0;

    // Write then read word 4, frame in TURN ignored, then a window miss.
    for (int i = 0; i < 12; i++) begin
      LBC_FRAME = tbl[i].frame;
      LBC_ADDR  = tbl[i].addr;
      LBC_CMD   = tbl[i].cmd;
      LBC_DATA  = tbl[i].data;
      LBC_IRDY  = 1'b1;
      check($sformatf("vec%0d", i), {SRT_SEL, SRT_TRDY, SRT_DOE, SRT_DATA}, 64'(tbl[i].exp));
      step();
    end
    LBC_FRAME = 1'b0;
    LBC_IRDY  = 1'b0;
    LBC_DATA  = '0;

    // 4-beat write at word 6 wraps to 4,5; read back from word 4.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    xfer(1'b1, 32'h1F00_0018, 4'hF, 2'b10, -1, 0, -1, done);
    check("wr4_beats", 64'(done), 64'd4);
    xfer(1'b0, 32'h1F00_0010, 4'hF, 2'b10, -1, 0, -1, done);
    check("rd4_w4", 64'(rbuf[0]), 64'd3);
    check("rd4_w5", 64'(rbuf[1]), 64'd4);
    check("rd4_w6", 64'(rbuf[2]), 64'd1);
    check("rd4_w7", 64'(rbuf[3]), 64'd2);

    // Byte-enable write over a zero word.
    wbuf[0] = 32'h0;
    xfer(1'b1, 32'h1F00_0050, 4'hF, 2'b00, -1, 0, -1, done);
    wbuf[0] = 32'hAABB_CCDD;
    xfer(1'b1, 32'h1F00_0050, 4'b0101, 2'b00, -1, 0, -1, done);
    xfer(1'b0, 32'h1F00_0050, 4'hF, 2'b00, -1, 0, -1, done);
    check("byte_en", 64'(rbuf[0]), 64'h00BB_00DD);

    // 8-beat read from word 11 with a 3-cycle IRDY stall before the 4th beat.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
    xfer(1'b1, 32'h1F00_0020, 4'hF, 2'b11, -1, 0, -1, done);
    xfer(1'b0, 32'h1F00_002C, 4'hF, 2'b11, 3, 3, -1, done);
    check("rd8_beats", 64'(done), 64'd8);
    check("rd8_turn", {SRT_SEL, SRT_TRDY, SRT_DOE, SRT_DATA}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd8_beat%0d", i), 64'(rbuf[i]), 64'(32'h100 + 32'((3 + i) % 8)));
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd8_stall%0d", i), 64'(stall_log[i]), 64'h106);
    end

    // Abort on the second beat of a 4-beat write: only beat 1 lands.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h1111_1111;
    xfer(1'b1, 32'h1F00_0060, 4'hF, 2'b10, -1, 0, -1, done);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
    xfer(1'b1, 32'h1F00_0060, 4'hF, 2'b10, -1, 0, 1, done);
    check("abort_beats", 64'(done), 64'd1);
    check("abort_idle", {SRT_SEL, SRT_TRDY}, 64'h0);
    xfer(1'b0, 32'h1F00_0060, 4'hF, 2'b10, -1, 0, -1, done);
    check("abort_w24", 64'(rbuf[0]), 64'hC0);
    check("abort_w25", 64'(rbuf[1]), 64'h1111_1111);
    check("abort_w26", 64'(rbuf[2]), 64'h1111_1111);
    check("abort_w27", 64'(rbuf[3]), 64'h1111_1111);

    // Reset coinciding with a completing write beat drops the write.
    wbuf[0] = 32'h5555_AAAA;
    xfer(1'b1, 32'h1F00_0078, 4'hF, 2'b00, -1, 0, -1, done);
    step();
    LBC_FRAME = 1'b1;
    LBC_ADDR  = 32'h1F00_0078;
    LBC_CMD   = 7'h1F;
    step();
    LBC_FRAME = 1'b0;
    LBC_ADDR  = '0;
    LBC_CMD   = '0;
    step();
    check("rst_mid_trdy", 64'(SRT_TRDY), 64'd1);
    LBC_IRDY   = 1'b1;
    LBC_DATA   = 32'hFFFF_FFFF;
    RESET_D1_R = 1'b1;
    step();
    RESET_D1_R = 1'b0;
    LBC_IRDY   = 1'b0;
    LBC_DATA   = '0;
    check("rst_mid_outputs", {SRT_SEL, SRT_TRDY, SRT_DOE, SRT_DATA}, 64'h0);
    xfer(1'b0, 32'h1F00_0078, 4'hF, 2'b00, -1, 0, -1, done);
    check("rst_mid_mem", 64'(rbuf[0]), 64'h5555_AAAA);

`ifdef LBUS_SRT_WRPROT_EN
    wbuf[0] = 32'h0;
    xfer(1'b1, 32'h1F00_00A0, 4'hF, 2'b00, -1, 0, -1, done);
    check("wp_err_idle", 64'(SRT_ERR), 64'd0);
    SRT_WP  = 1'b1;
    wbuf[0] = 32'h1234_5678;
    xfer(1'b1, 32'h1F00_00A0, 4'hF, 2'b00, -1, 0, -1, done);
    check("wp_err_pulse", 64'(SRT_ERR), 64'd1);
    step();
    check("wp_err_clear", 64'(SRT_ERR), 64'd0);
    SRT_WP = 1'b0;
    xfer(1'b0, 32'h1F00_00A0, 4'hF, 2'b00, -1, 0, -1, done);
    check("wp_mem", 64'(rbuf[0]), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
